// File: rtl/bin_states_mover.sv
// ============================================================================
// Module   : bin_states_mover
// Purpose  : Moves variable state words between the global state RAM and the
//            base cells of the active bin (load: RAM->cells, update: cells->RAM).
//            Optional macro BIN_STATES_CLEAR_EN zeroes cells of unused slots on load.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_states_mover #(
    parameter int NUM_VARS_A_BIN   = 8,
    parameter int WIDTH_VAR_STATES = 30,
    parameter int WIDTH_VAR_INDEX  = 12
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start_load_i,
    input  logic                                        start_update_i,
    input  logic [NUM_VARS_A_BIN*WIDTH_VAR_INDEX-1:0]   var_idx_i,
    output logic                                        busy_o,
    output logic                                        done_load_o,
    output logic                                        done_update_o,
    output logic                                        ram_rd_en_o,
    output logic                                        ram_wr_en_o,
    output logic [WIDTH_VAR_INDEX-1:0]                  ram_addr_o,
    input  logic [WIDTH_VAR_STATES-1:0]                 ram_rd_data_i,
    output logic [WIDTH_VAR_STATES-1:0]                 ram_wr_data_o,
    output logic [NUM_VARS_A_BIN-1:0]                   wr_states_o,
    output logic [WIDTH_VAR_STATES-1:0]                 vars_states_o,
    input  logic [NUM_VARS_A_BIN*WIDTH_VAR_STATES-1:0]  vars_states_i
);

    localparam int SLOT_W = $clog2(NUM_VARS_A_BIN + 1);
    localparam int TAG_W  = (NUM_VARS_A_BIN > 1) ? $clog2(NUM_VARS_A_BIN) : 1;
    localparam logic [SLOT_W-1:0] SLOT_END = SLOT_W'(NUM_VARS_A_BIN);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        LOAD_TAIL = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t                                     state;
    logic [SLOT_W-1:0]                          slot;
    logic [NUM_VARS_A_BIN*WIDTH_VAR_INDEX-1:0]  idx;
    logic                                       pend_valid;
    logic                                       pend_fill;
    logic [TAG_W-1:0]                           pend_tag;
    logic                                       data_sel;

    logic [TAG_W-1:0]            cur_tag;
    logic [WIDTH_VAR_INDEX-1:0]  cur_idx;
    logic [WIDTH_VAR_STATES-1:0] cur_state;
    logic                        issue_ld;
    logic                        issue_up;

    // The first slot is issued on the accepting edge, so in IDLE the slot
    // index comes straight from the inputs rather than the latched copy.
    always_comb begin
        cur_tag   = (state == IDLE) ? '0 : slot[TAG_W-1:0];
        cur_idx   = (state == IDLE) ? var_idx_i[0 +: WIDTH_VAR_INDEX]
                                    : idx[cur_tag*WIDTH_VAR_INDEX +: WIDTH_VAR_INDEX];
        cur_state = vars_states_i[cur_tag*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
        issue_ld  = ((state == IDLE) && start_load_i) ||
                    ((state == LOAD) && (slot != SLOT_END));
        issue_up  = ((state == IDLE) && !start_load_i && start_update_i) ||
                    ((state == UPDATE) && (slot != SLOT_END));
    end

    // RAM data arrives in the same cycle as the cell strobe, so the broadcast
    // word is the RAM bus gated by a registered select.
    assign vars_states_o = data_sel ? ram_rd_data_i : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            slot          <= '0;
            idx           <= '0;
            pend_valid    <= 1'b0;
            pend_fill     <= 1'b0;
            pend_tag      <= '0;
            data_sel      <= 1'b0;
            busy_o        <= 1'b0;
            done_load_o   <= 1'b0;
            done_update_o <= 1'b0;
            ram_rd_en_o   <= 1'b0;
            ram_wr_en_o   <= 1'b0;
            ram_addr_o    <= '0;
            ram_wr_data_o <= '0;
            wr_states_o   <= '0;
        end else begin
            done_load_o   <= 1'b0;
            done_update_o <= 1'b0;
            ram_rd_en_o   <= 1'b0;
            ram_wr_en_o   <= 1'b0;
            pend_valid    <= 1'b0;
            wr_states_o   <= '0;
            data_sel      <= 1'b0;

            if (pend_valid) begin
                wr_states_o <= NUM_VARS_A_BIN'(1) << pend_tag;
                data_sel    <= pend_fill;
            end

            if (issue_ld) begin
                if (cur_idx != '0) begin
                    ram_rd_en_o <= 1'b1;
                    ram_addr_o  <= cur_idx;
                    pend_valid  <= 1'b1;
                    pend_tag    <= cur_tag;
                    pend_fill   <= 1'b1;
                end
`ifdef BIN_STATES_CLEAR_EN
                else begin
                    pend_valid  <= 1'b1;
                    pend_tag    <= cur_tag;
                    pend_fill   <= 1'b0;
                end
`endif
            end

            if (issue_up && (cur_idx != '0)) begin
                ram_wr_en_o   <= 1'b1;
                ram_addr_o    <= cur_idx;
                ram_wr_data_o <= cur_state;
            end

            case (state)
                IDLE: begin
                    if (start_load_i || start_update_i) begin
                        idx    <= var_idx_i;
                        slot   <= SLOT_W'(1);
                        busy_o <= 1'b1;
                        state  <= start_load_i ? LOAD : UPDATE;
                    end
                end
                LOAD: begin
                    if (slot == SLOT_END) begin
                        slot  <= '0;
                        state <= LOAD_TAIL;
                    end else begin
                        slot  <= slot + 1'b1;
                    end
                end
                LOAD_TAIL: begin
                    busy_o      <= 1'b0;
                    done_load_o <= 1'b1;
                    state       <= IDLE;
                end
                UPDATE: begin
                    if (slot == SLOT_END) begin
                        slot          <= '0;
                        busy_o        <= 1'b0;
                        done_update_o <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        slot          <= slot + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bin_states_mover.sv
// ============================================================================
// Module   : tb_bin_states_mover
// Purpose  : Self-checking bench for bin_states_mover against a slot/cycle
//            reference model, a behavioural RAM and emulated base cells.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bin_states_mover;

    localparam int N  = 8;
    localparam int IW = 12;
    localparam int SW = 30;
`ifdef BIN_STATES_CLEAR_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_load_i = 1'b0;
    logic              start_update_i = 1'b0;
    logic [N*IW-1:0]   var_idx_i = '0;
    logic              busy_o, done_load_o, done_update_o;
    logic              ram_rd_en_o, ram_wr_en_o;
    logic [IW-1:0]     ram_addr_o;
    logic [SW-1:0]     ram_rd_data_i;
    logic [SW-1:0]     ram_wr_data_o;
    logic [N-1:0]      wr_states_o;
    logic [SW-1:0]     vars_states_o;
    logic [N*SW-1:0]   vars_states_i;

    int checks = 0;
    int failures = 0;

    bin_states_mover #(
        .NUM_VARS_A_BIN  (N),
        .WIDTH_VAR_STATES(SW),
        .WIDTH_VAR_INDEX (IW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_load_i  (start_load_i),
        .start_update_i(start_update_i),
        .var_idx_i     (var_idx_i),
        .busy_o        (busy_o),
        .done_load_o   (done_load_o),
        .done_update_o (done_update_o),
        .ram_rd_en_o   (ram_rd_en_o),
        .ram_wr_en_o   (ram_wr_en_o),
        .ram_addr_o    (ram_addr_o),
        .ram_rd_data_i (ram_rd_data_i),
        .ram_wr_data_o (ram_wr_data_o),
        .wr_states_o   (wr_states_o),
        .vars_states_o (vars_states_o),
        .vars_states_i (vars_states_i)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: unwritten words read as addr*0x111, 1-cycle read latency.
    logic [SW-1:0] ram_mem  [4096];
    bit            ram_flag [4096];

    function automatic logic [SW-1:0] base_word(input int a);
        return SW'(a * 32'h111);
    endfunction

    function automatic logic [SW-1:0] ram_word(input int a);
        return ram_flag[a] ? ram_mem[a] : base_word(a);
    endfunction

    always @(posedge clk) begin
        if (ram_wr_en_o) begin
            ram_mem[ram_addr_o]  <= ram_wr_data_o;
            ram_flag[ram_addr_o] <= 1'b1;
        end
        if (ram_rd_en_o)
            ram_rd_data_i <= ram_word(int'(ram_addr_o));
    end

    // Emulated base cells latching the broadcast word on their strobe.
    logic [SW-1:0] cell_q [N];
    always @(posedge clk) begin
        for (int k = 0; k < N; k++)
            if (wr_states_o[k]) cell_q[k] <= vars_states_o;
    end

    // States presented by the cells for update.
    logic [SW-1:0] cell_in [N];
    always_comb begin
        vars_states_i = '0;
        for (int k = 0; k < N; k++)
            vars_states_i[k*SW +: SW] = cell_in[k];
    end

    // Reference model state.
    logic [SW-1:0] mdl_mem  [4096];
    bit            mdl_flag [4096];
    logic [SW-1:0] mdl_cell [N];
    bit            cell_known [N];

    function automatic logic [SW-1:0] model_word(input int a);
        return mdl_flag[a] ? mdl_mem[a] : base_word(a);
    endfunction

    function automatic int idx_at(input logic [N*IW-1:0] v, input int k);
        return int'(v[k*IW +: IW]);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_strobes"}, {busy_o, done_load_o, done_update_o, ram_rd_en_o, ram_wr_en_o, wr_states_o}, '0);
        check({tag, "_addr_wdata"}, {ram_addr_o, ram_wr_data_o}, '0);
        check({tag, "_vstates"}, vars_states_o, '0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle_busy", busy_o, 1'b0);
            check("idle_access", {ram_rd_en_o, ram_wr_en_o, wr_states_o, done_load_o, done_update_o}, '0);
            @(negedge clk);
        end
    endtask

    task automatic run_load(input logic [N*IW-1:0] iv, input bit both, input int inject_cyc, input int abort_cyc);
        logic [SW-1:0] exp_word [N];
        logic [N-1:0]  exp_ws;
        logic [SW-1:0] exp_vs;
        bit            exp_rd;
        for (int k = 0; k < N; k++)
            exp_word[k] = (idx_at(iv, k) != 0) ? model_word(idx_at(iv, k)) : '0;
        @(negedge clk);
        var_idx_i      = iv;
        start_load_i   = 1'b1;
        start_update_i = both;
        @(negedge clk);
        start_load_i   = 1'b0;
        start_update_i = 1'b0;
        for (int c = 1; c <= N + 2; c++) begin
            if (c == abort_cyc) begin
                #2 rst = 1'b0;
                #1 check_quiet("abort");
                @(negedge clk);
                rst = 1'b1;
                for (int k = 0; k < N; k++) cell_known[k] = 1'b0;
                idle_cycles(4);
                return;
            end
            exp_rd = (c <= N) && (idx_at(iv, c - 1) != 0);
            check("ld_rd_en", ram_rd_en_o, exp_rd);
            if (exp_rd) check("ld_addr", ram_addr_o, idx_at(iv, c - 1));
            exp_ws = '0;
            exp_vs = '0;
            if (c >= 2 && c <= N + 1 && (idx_at(iv, c - 2) != 0 || CLEAR)) begin
                exp_ws = N'(1) << (c - 2);
                exp_vs = exp_word[c - 2];
            end
            check("ld_wr_states", wr_states_o, exp_ws);
            if (exp_ws != '0) check("ld_data", vars_states_o, exp_vs);
            check("ld_wr_en", ram_wr_en_o, 1'b0);
            check("ld_busy", busy_o, c <= N + 1);
            check("ld_done", done_load_o, c == N + 2);
            check("ld_done_upd", done_update_o, 1'b0);
            check("onehot", $onehot0(wr_states_o), 1'b1);
            if (c == inject_cyc) start_update_i = 1'b1;
            @(negedge clk);
            start_update_i = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            if (idx_at(iv, k) != 0 || CLEAR) begin
                mdl_cell[k]   = exp_word[k];
                cell_known[k] = 1'b1;
            end
            if (cell_known[k]) check("cell", cell_q[k], mdl_cell[k]);
        end
        idle_cycles(3);
    endtask

    task automatic run_update(input logic [N*IW-1:0] iv, input bit rand_data);
        bit exp_wr;
        for (int k = 0; k < N; k++)
            cell_in[k] = rand_data ? SW'($urandom) : SW'(32'hA + k);
        @(negedge clk);
        var_idx_i      = iv;
        start_update_i = 1'b1;
        @(negedge clk);
        start_update_i = 1'b0;
        for (int c = 1; c <= N + 1; c++) begin
            exp_wr = (c <= N) && (idx_at(iv, c - 1) != 0);
            check("up_wr_en", ram_wr_en_o, exp_wr);
            if (exp_wr) begin
                check("up_addr", ram_addr_o, idx_at(iv, c - 1));
                check("up_wdata", ram_wr_data_o, cell_in[c - 1]);
            end
            check("up_rd_en", ram_rd_en_o, 1'b0);
            check("up_wr_states", wr_states_o, '0);
            check("up_busy", busy_o, c <= N);
            check("up_done", done_update_o, c == N + 1);
            check("up_done_ld", done_load_o, 1'b0);
            @(negedge clk);
        end
        for (int k = 0; k < N; k++) begin
            if (idx_at(iv, k) != 0) begin
                mdl_mem[idx_at(iv, k)]  = cell_in[k];
                mdl_flag[idx_at(iv, k)] = 1'b1;
            end
        end
        for (int k = 0; k < N; k++)
            if (idx_at(iv, k) != 0)
                check("ram_content", ram_word(idx_at(iv, k)), model_word(idx_at(iv, k)));
        idle_cycles(2);
    endtask

    function automatic logic [N*IW-1:0] rand_idx();
        logic [N*IW-1:0] v;
        for (int k = 0; k < N; k++)
            v[k*IW +: IW] = ($urandom_range(0, 2) == 0) ? '0 : IW'($urandom_range(1, 40));
        return v;
    endfunction

    initial begin
        logic [N*IW-1:0] iv;
        for (int k = 0; k < N; k++) begin
            cell_in[k]    = '0;
            cell_known[k] = 1'b0;
            mdl_cell[k]   = '0;
        end
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b1;
        @(negedge clk);
        check_quiet("post_reset");

        for (int k = 0; k < N; k++) iv[k*IW +: IW] = IW'(k + 1);
        run_load(iv, 1'b0, 0, 0);

        iv = '0;
        iv[0*IW +: IW] = IW'(5);
        iv[2*IW +: IW] = IW'(7);
        iv[7*IW +: IW] = IW'(9);
        run_update(iv, 1'b0);

        for (int k = 0; k < N; k++) iv[k*IW +: IW] = IW'(k + 3);
        run_load(iv, 1'b1, 0, 0);
        run_load(iv, 1'b0, 4, 0);
        run_load(iv, 1'b0, 0, 5);

        for (int k = 0; k < N; k++) iv[k*IW +: IW] = IW'(k + 10);
        iv[2*IW +: IW] = '0;
        run_load(iv, 1'b0, 0, 0);

        for (int t = 0; t < 24; t++) begin
            iv = rand_idx();
            if ($urandom_range(0, 1) == 0) run_load(iv, 1'b0, 0, 0);
            else                           run_update(iv, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
